accelerator_write_weighting_stream: RTL and testbench



---
 rtl/accelerator_write_weighting_stream_if.sv | 29 ++
 rtl/accelerator_write_weighting_stream.sv | 145 ++++++++++++++
 tb/tb_accelerator_write_weighting_stream.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/accelerator_write_weighting_stream_if.sv
// rtl/accelerator_write_weighting_stream_if.sv - handshake and data bundle for the write-weighting stream
`timescale 1ns/1ps
interface accelerator_write_weighting_stream_if #(
  parameter int DATA_SIZE = 32
);
  logic                 START;
  logic                 READY;
  logic                 A_IN_ENABLE;
  logic                 C_IN_ENABLE;
  logic                 A_OUT_ENABLE;
  logic                 C_OUT_ENABLE;
  logic                 W_OUT_ENABLE;
  logic [DATA_SIZE-1:0] SIZE_N_IN;
  logic [DATA_SIZE-1:0] A_IN;
  logic [DATA_SIZE-1:0] C_IN;
  logic [DATA_SIZE-1:0] GA_IN;
  logic [DATA_SIZE-1:0] GW_IN;
  logic [DATA_SIZE-1:0] W_OUT;

  modport master (
    output START, A_IN_ENABLE, C_IN_ENABLE, SIZE_N_IN, A_IN, C_IN, GA_IN, GW_IN,
    input  READY, A_OUT_ENABLE, C_OUT_ENABLE, W_OUT_ENABLE, W_OUT
  );

  modport slave (
    input  START, A_IN_ENABLE, C_IN_ENABLE, SIZE_N_IN, A_IN, C_IN, GA_IN, GW_IN,
    output READY, A_OUT_ENABLE, C_OUT_ENABLE, W_OUT_ENABLE, W_OUT
  );
endinterface

// File: rtl/accelerator_write_weighting_stream.sv
// rtl/accelerator_write_weighting_stream.sv - streaming DNC write weighting w = gw*(ga*a + (1-ga)*c)
// Optional ACCELERATOR_WRITE_WEIGHTING_SATURATE_EN clamps gates to ONE and saturates both stages.
`timescale 1ns/1ps
module accelerator_write_weighting_stream #(
  parameter int DATA_SIZE     = 32,
  parameter int FRACTION_SIZE = 16
) (
  input logic                                 CLK,
  input logic                                 RST,
  accelerator_write_weighting_stream_if.slave bus
);
  localparam int PW  = 2*DATA_SIZE + 1;
  localparam int PW2 = 2*DATA_SIZE;
  localparam logic [DATA_SIZE-1:0] ONE = DATA_SIZE'(1) << FRACTION_SIZE;

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;
  state_t state, state_next;

  logic [DATA_SIZE-1:0] n_reg, ga_reg, gw_reg, omg_reg;
  logic [DATA_SIZE-1:0] a_count, c_count, w_count;
  logic [DATA_SIZE-1:0] a_hold, c_hold, p_a, p_c, s1_t, w_reg;
  logic                 a_held, c_held, p_valid, s1_valid, w_valid, ready_reg;

  logic                 a_en, c_en, a_acc, c_acc, fire, last_out, ready_next;
  logic [DATA_SIZE-1:0] pair_a, pair_c, ga_lat, gw_lat, t_next, w_next;
  logic [PW-1:0]        sum1;
  logic [PW2-1:0]       prod2;

  always_comb begin
    a_en     = (state == STREAM) && (a_count < n_reg) && !a_held;
    c_en     = (state == STREAM) && (c_count < n_reg) && !c_held;
    a_acc    = a_en && bus.A_IN_ENABLE;
    c_acc    = c_en && bus.C_IN_ENABLE;
    fire     = (a_held || a_acc) && (c_held || c_acc);
    pair_a   = a_held ? a_hold : bus.A_IN;
    pair_c   = c_held ? c_hold : bus.C_IN;
    last_out = s1_valid && ((w_count + DATA_SIZE'(1)) == n_reg);
  end

  always_comb begin
`ifdef ACCELERATOR_WRITE_WEIGHTING_SATURATE_EN
    ga_lat = (bus.GA_IN > ONE) ? ONE : bus.GA_IN;
    gw_lat = (bus.GW_IN > ONE) ? ONE : bus.GW_IN;
`else
    ga_lat = bus.GA_IN;
    gw_lat = bus.GW_IN;
`endif
  end

  // Shift is applied to the full-width sum so both terms share one rounding point
  always_comb begin
    sum1  = PW'(ga_reg) * PW'(p_a) + PW'(omg_reg) * PW'(p_c);
    prod2 = PW2'(gw_reg) * PW2'(s1_t);
`ifdef ACCELERATOR_WRITE_WEIGHTING_SATURATE_EN
    t_next = ((sum1 >> FRACTION_SIZE) > PW'({DATA_SIZE{1'b1}})) ? '1
           : DATA_SIZE'(sum1 >> FRACTION_SIZE);
    w_next = ((prod2 >> FRACTION_SIZE) > PW2'({DATA_SIZE{1'b1}})) ? '1
           : DATA_SIZE'(prod2 >> FRACTION_SIZE);
`else
    t_next = DATA_SIZE'(sum1 >> FRACTION_SIZE);
    w_next = DATA_SIZE'(prod2 >> FRACTION_SIZE);
`endif
  end

  always_comb begin
    state_next = state;
    ready_next = 1'b0;
    case (state)
      IDLE: begin
        if (bus.START) begin
          if (bus.SIZE_N_IN == '0) begin
            state_next = DONE;
            ready_next = 1'b1;
          end else begin
            state_next = STREAM;
          end
        end
      end
      STREAM: if ((a_count == n_reg) && (c_count == n_reg)) state_next = DRAIN;
      DRAIN: begin
        if (last_out) begin
          state_next = IDLE;
          ready_next = 1'b1;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      n_reg <= '0; ga_reg <= '0; gw_reg <= '0; omg_reg <= '0;
      a_count <= '0; c_count <= '0; w_count <= '0;
      a_held <= 1'b0; c_held <= 1'b0; a_hold <= '0; c_hold <= '0;
      p_valid <= 1'b0; p_a <= '0; p_c <= '0;
      s1_valid <= 1'b0; s1_t <= '0;
      w_valid <= 1'b0; w_reg <= '0; ready_reg <= 1'b0;
    end else begin
      if ((state == IDLE) && bus.START) begin
        n_reg   <= bus.SIZE_N_IN;
        ga_reg  <= ga_lat;
        gw_reg  <= gw_lat;
        omg_reg <= ONE - ga_lat;
        a_count <= '0;
        c_count <= '0;
        w_count <= '0;
        a_held  <= 1'b0;
        c_held  <= 1'b0;
      end else begin
        if (a_acc) a_count <= a_count + DATA_SIZE'(1);
        if (c_acc) c_count <= c_count + DATA_SIZE'(1);
        if (fire) begin
          a_held <= 1'b0;
          c_held <= 1'b0;
        end else begin
          if (a_acc) begin a_held <= 1'b1; a_hold <= bus.A_IN; end
          if (c_acc) begin c_held <= 1'b1; c_hold <= bus.C_IN; end
        end
        if (s1_valid && (w_count < n_reg)) w_count <= w_count + DATA_SIZE'(1);
      end
      p_valid <= fire;
      if (fire) begin
        p_a <= pair_a;
        p_c <= pair_c;
      end
      s1_valid <= p_valid;
      if (p_valid) s1_t <= t_next;
      w_valid <= s1_valid;
      if (s1_valid) w_reg <= w_next;
      ready_reg <= ready_next;
    end
  end

  assign bus.READY        = ready_reg;
  assign bus.A_OUT_ENABLE = a_en;
  assign bus.C_OUT_ENABLE = c_en;
  assign bus.W_OUT_ENABLE = w_valid;
  assign bus.W_OUT        = w_reg;
endmodule

// File: tb/tb_accelerator_write_weighting_stream.sv
// tb/tb_accelerator_write_weighting_stream.sv - scoreboard bench for accelerator_write_weighting_stream
`timescale 1ns/1ps
module tb_accelerator_write_weighting_stream;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  accelerator_write_weighting_stream_if #(.DATA_SIZE(32)) bus ();

  accelerator_write_weighting_stream #(.DATA_SIZE(32), .FRACTION_SIZE(16)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  typedef struct { logic [31:0] w; bit last; bit zero; } exp_t;
  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   out_seen = 0;
  bit   abort = 0;

  logic [31:0] a_vals[8], c_vals[8], w_exp[8];
  int          a_gap[8], c_gap[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: every output event must match the head of the scoreboard
  always @(negedge CLK) begin
    if (!RST && (bus.W_OUT_ENABLE || bus.READY)) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output w_en=%0b w=%h ready=%0b", bus.W_OUT_ENABLE, bus.W_OUT, bus.READY);
      end else begin
        mon_e = sb.pop_front();
        if ((bus.W_OUT_ENABLE !== !mon_e.zero) || (!mon_e.zero && (bus.W_OUT !== mon_e.w)) ||
            (bus.READY !== mon_e.last)) begin
          errors++;
          $display("FAIL sb_out actual w_en=%0b w=%h ready=%0b required w_en=%0b w=%h ready=%0b",
                   bus.W_OUT_ENABLE, bus.W_OUT, bus.READY, !mon_e.zero, mon_e.w, mon_e.last);
        end
        out_seen++;
      end
    end
  end

  task automatic push_exp(input int n);
    if (n == 0) sb.push_back('{w: 32'h0, last: 1'b1, zero: 1'b1});
    for (int i = 0; i < n; i++) sb.push_back('{w: w_exp[i], last: (i == n-1), zero: 1'b0});
  endtask

  task automatic do_start(input logic [31:0] n, input logic [31:0] ga, input logic [31:0] gw);
    @(posedge CLK); #1;
    bus.START = 1'b1; bus.SIZE_N_IN = n; bus.GA_IN = ga; bus.GW_IN = gw;
    @(posedge CLK); #1;
    bus.START = 1'b0;
  endtask

  task automatic drive_a(input int n);
    bit acc;
    int t;
    for (int i = 0; i < n && !abort; i++) begin
      bus.A_IN_ENABLE = 1'b0;
      repeat (a_gap[i]) begin @(posedge CLK); #1; end
      bus.A_IN = a_vals[i]; bus.A_IN_ENABLE = 1'b1;
      acc = 0; t = 0;
      while (!acc && !abort && t < 100) begin
        @(negedge CLK); acc = bus.A_OUT_ENABLE;
        @(posedge CLK); #1; t++;
      end
      if (!abort) check("a_accept", 32'(acc), 32'd1);
    end
    bus.A_IN_ENABLE = 1'b0;
  endtask

  task automatic drive_c(input int n);
    bit acc;
    int t;
    for (int i = 0; i < n && !abort; i++) begin
      bus.C_IN_ENABLE = 1'b0;
      repeat (c_gap[i]) begin @(posedge CLK); #1; end
      bus.C_IN = c_vals[i]; bus.C_IN_ENABLE = 1'b1;
      acc = 0; t = 0;
      while (!acc && !abort && t < 100) begin
        @(negedge CLK); acc = bus.C_OUT_ENABLE;
        @(posedge CLK); #1; t++;
      end
      if (!abort) check("c_accept", 32'(acc), 32'd1);
    end
    bus.C_IN_ENABLE = 1'b0;
  endtask

  task automatic wait_drain();
    int t = 0;
    while (sb.size() != 0 && t < 200) begin @(negedge CLK); t++; end
    check("drain_empty", 32'(sb.size()), 32'd0);
    repeat (2) @(negedge CLK);
  endtask

  task automatic run(input int n, input logic [31:0] ga, input logic [31:0] gw);
    push_exp(n);
    do_start(32'(n), ga, gw);
    fork
      drive_a(n);
      drive_c(n);
    join
    wait_drain();
  endtask

  task automatic fill(input int n, input logic [31:0] a, input logic [31:0] c, input logic [31:0] w);
    for (int i = 0; i < n; i++) begin
      a_vals[i] = a; c_vals[i] = c; w_exp[i] = w; a_gap[i] = 0; c_gap[i] = 0;
    end
  endtask

  task automatic burst_watch();
    int t = 0;
    do begin @(negedge CLK); t++; end while (!bus.W_OUT_ENABLE && t < 50);
    check("burst_first", 32'(bus.W_OUT_ENABLE), 32'd1);
    for (int i = 1; i < 4; i++) begin
      @(negedge CLK);
      check("burst_consecutive", 32'(bus.W_OUT_ENABLE), 32'd1);
    end
  endtask

  task automatic skew_watch();
    @(negedge CLK);
    check("skew_a_en_first", 32'(bus.A_OUT_ENABLE), 32'd1);
    @(negedge CLK);
    check("skew_a_en_held", 32'(bus.A_OUT_ENABLE), 32'd0);
    @(negedge CLK);
    check("skew_a_en_still_held", 32'(bus.A_OUT_ENABLE), 32'd0);
  endtask

  task automatic reset_watch();
    int t = 0;
    do begin @(negedge CLK); #1; t++; end while ((out_seen < 3) && t < 100);
    check("rst_three_outputs", 32'(out_seen), 32'd3);
    RST = 1'b1; abort = 1'b1;
    sb.delete();
    #1;
    check("rst_w_en", 32'(bus.W_OUT_ENABLE), 32'd0);
    check("rst_w_out", bus.W_OUT, 32'd0);
    check("rst_ready", 32'(bus.READY), 32'd0);
    check("rst_a_en", 32'(bus.A_OUT_ENABLE), 32'd0);
    check("rst_c_en", 32'(bus.C_OUT_ENABLE), 32'd0);
    repeat (2) @(negedge CLK);
    RST = 1'b0;
  endtask

  initial begin
    bus.START = 1'b0; bus.A_IN_ENABLE = 1'b0; bus.C_IN_ENABLE = 1'b0;
    bus.SIZE_N_IN = '0; bus.A_IN = '0; bus.C_IN = '0; bus.GA_IN = '0; bus.GW_IN = '0;
    repeat (3) @(posedge CLK);
    #1;
    check("reset_ready", 32'(bus.READY), 32'd0);
    check("reset_a_en", 32'(bus.A_OUT_ENABLE), 32'd0);
    check("reset_c_en", 32'(bus.C_OUT_ENABLE), 32'd0);
    check("reset_w_en", 32'(bus.W_OUT_ENABLE), 32'd0);
    check("reset_w_out", bus.W_OUT, 32'd0);
    @(negedge CLK); RST = 1'b0;

    // Basic pair with latency: fire edge, two pipeline edges, then valid
    fill(1, 32'h0001_0000, 32'h0, 32'h0000_8000);
    push_exp(1);
    do_start(32'd1, 32'h0000_8000, 32'h0001_0000);
    bus.A_IN = 32'h0001_0000; bus.C_IN = 32'h0; bus.A_IN_ENABLE = 1'b1; bus.C_IN_ENABLE = 1'b1;
    @(negedge CLK);
    check("basic_a_en", 32'(bus.A_OUT_ENABLE), 32'd1);
    @(posedge CLK); #1;
    bus.A_IN_ENABLE = 1'b0; bus.C_IN_ENABLE = 1'b0;
    @(negedge CLK); check("basic_lat1", 32'(bus.W_OUT_ENABLE), 32'd0);
    @(negedge CLK); check("basic_lat2", 32'(bus.W_OUT_ENABLE), 32'd0);
    @(negedge CLK); check("basic_lat3", 32'(bus.W_OUT_ENABLE), 32'd1);
    check("basic_ready", 32'(bus.READY), 32'd1);
    wait_drain();

    // Full-rate burst: t = 0.25*1 + 0.75*0.5 = 0.625, w = 0.3125
    fill(4, 32'h0001_0000, 32'h0000_8000, 32'h0000_5000);
    push_exp(4);
    do_start(32'd4, 32'h0000_4000, 32'h0000_8000);
    fork
      drive_a(4);
      drive_c(4);
      burst_watch();
    join
    wait_drain();

    // Skewed: C withheld while the first A sits in its holding register
    fill(2, 32'h0, 32'h0, 32'h0);
    a_vals[0] = 32'h0001_0000; c_vals[0] = 32'h0;          w_exp[0] = 32'h0000_8000;
    a_vals[1] = 32'h0;          c_vals[1] = 32'h0001_0000; w_exp[1] = 32'h0000_8000;
    a_vals[1] = 32'h0002_0000; w_exp[1] = 32'h0001_8000;
    c_gap[0] = 4;
    push_exp(2);
    do_start(32'd2, 32'h0000_8000, 32'h0001_0000);
    fork
      drive_a(2);
      drive_c(2);
      skew_watch();
    join
    wait_drain();

    // Zero length followed by a normal START
    push_exp(0);
    do_start(32'd0, 32'h0000_8000, 32'h0001_0000);
    wait_drain();
    fill(1, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000);
    run(1, 32'h0000_8000, 32'h0001_0000);

    // Reset after three outputs of an eight-element stream
    fill(8, 32'h0001_0000, 32'h0, 32'h0000_8000);
    push_exp(8);
    out_seen = 0;
    do_start(32'd8, 32'h0000_8000, 32'h0001_0000);
    fork
      drive_a(8);
      drive_c(8);
      reset_watch();
    join
    abort = 1'b0;
    repeat (4) @(negedge CLK);
    fill(1, 32'h0001_0000, 32'h0, 32'h0000_8000);
    run(1, 32'h0000_8000, 32'h0001_0000);

    // Oversized gate: wrapped or clamped path both land on 0xFFFF0000
    fill(1, 32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000);
    run(1, 32'h0002_0000, 32'h0001_0000);

    // Mixed skew with distinct pairs: ga=0.75, gw=0.5
    fill(3, 32'h0, 32'h0, 32'h0);
    a_vals[0] = 32'h0000_8000; c_vals[0] = 32'h0001_0000; w_exp[0] = 32'h0000_5000;
    a_vals[1] = 32'h0002_0000; c_vals[1] = 32'h0;          w_exp[1] = 32'h0000_C000;
    a_vals[2] = 32'h0;          c_vals[2] = 32'h0003_0000; w_exp[2] = 32'h0000_6000;
    a_gap[1] = 2; c_gap[0] = 1; c_gap[2] = 3;
    run(3, 32'h0000_C000, 32'h0000_8000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end
endmodule
